// File: rtl/forward_arbiter.sv
// forward_arbiter
//   Round-robin arbiter sharing one AXI-Stream egress between N_PORT forward
//   requesters. A requester raises i_forward_req and gets a one-cycle grant
//   pulse on o_forward_resp. It then drains its packets through the egress mux.
//   The grant is held until the requester reports finish, no packet is open,
//   and the egress has been quiet for IDLE_GAP cycles. The pointer then
//   rotates past the released port.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_forward_req         per-port request level
//   o_forward_resp        per-port one-cycle grant pulse (one-hot)
//   i_forward_finish      per-port "buffer empty" level
//   s_axis_*              per-port ingress streams (tdata 64b, tkeep 8b per port)
//   m_axis_*              shared egress stream
//   o_grant_idx           currently / last granted port
//   o_busy                high while a grant is being issued or served
module forward_arbiter #(
    parameter int N_PORT   = 4,
    parameter int IDX_W    = $clog2(N_PORT),
    parameter int IDLE_GAP = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_PORT-1:0]     i_forward_req,
    output logic [N_PORT-1:0]     o_forward_resp,
    input  logic [N_PORT-1:0]     i_forward_finish,
    input  logic [N_PORT-1:0]     s_axis_tvalid,
    input  logic [64*N_PORT-1:0]  s_axis_tdata,
    input  logic [N_PORT-1:0]     s_axis_tlast,
    input  logic [8*N_PORT-1:0]   s_axis_tkeep,
    input  logic [N_PORT-1:0]     s_axis_tuser,
    output logic [N_PORT-1:0]     s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [63:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [IDX_W-1:0]      o_grant_idx,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_RELEASE
    } state_t;

    localparam int unsigned       NP       = N_PORT;
    localparam logic [7:0]        GAP      = 8'(IDLE_GAP);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PORT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             pick_found;
    logic             in_pkt;
    logic [7:0]       idle_cnt;
    logic             sel_finish;
    logic             beat;
    logic             release_ok;
    int unsigned      cand;

    // Round-robin search: first requesting port at or after rr_ptr, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            cand     = (32'(rr_ptr) + i) % NP;
            cand_idx = IDX_W'(cand);
            if (!pick_found && i_forward_req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Egress mux: only the granted port is connected, and only while BUSY.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (state == S_BUSY && grant_idx == IDX_W'(k)) begin
                m_axis_tvalid    = s_axis_tvalid[k];
                m_axis_tdata     = s_axis_tdata[64*k +: 64];
                m_axis_tlast     = s_axis_tlast[k];
                m_axis_tkeep     = s_axis_tkeep[8*k +: 8];
                m_axis_tuser     = s_axis_tuser[k];
                s_axis_tready[k] = m_axis_tready;
            end
        end
    end

    assign sel_finish  = i_forward_finish[grant_idx];
    assign beat        = m_axis_tvalid && m_axis_tready;
    assign release_ok  = sel_finish && !in_pkt && (idle_cnt == GAP);
    assign o_grant_idx = grant_idx;
    assign o_busy      = (state == S_GRANT) || (state == S_BUSY);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        o_forward_resp = '0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                o_forward_resp[grant_idx] = 1'b1;
                state_nxt                 = S_BUSY;
            end
            S_BUSY: begin
                if (release_ok) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            in_pkt    <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        in_pkt    <= 1'b0;
                        idle_cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    if (beat) begin
                        in_pkt <= !m_axis_tlast;
                    end
                    // Quiet time only accumulates while the requester is empty
                    // and presents nothing; any refill restarts the count.
                    if (m_axis_tvalid || !sel_finish) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != GAP) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
